// File: rtl/keypad_scan_pkg.sv
// Shared key codes, scan states and decode helpers for the keypad scanner.
package keypad_scan_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KeyStar  = 4'd10;
    localparam key_code_t KeyHash  = 4'd11;
    localparam key_code_t KeyMulti = 4'hE;
    localparam key_code_t KeyNone  = 4'hF;

    // Column scanner states; StIdle only exists between reset and the first scan slot.
    typedef enum logic [1:0] {
        StIdle,
        StCol0,
        StCol1,
        StCol2
    } scan_state_e;

    // Matrix position to key code:
    //   r0 = 1 2 3, r1 = 4 5 6, r2 = 7 8 9, r3 = * 0 #
    function automatic key_code_t key_code(input logic [1:0] row, input logic [1:0] col);
        key_code_t code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KeyStar;
                2'd1:    code = 4'd0;
                default: code = KeyHash;
            endcase
        end else begin
            code = key_code_t'({2'b00, row}) * 4'd3 + key_code_t'({2'b00, col}) + 4'd1;
        end
        return code;
    endfunction

    // One-hot digit bus; anything other than 0-9 maps to all-zero.
    function automatic logic [9:0] key_onehot(input key_code_t code);
        logic [9:0] bus;
        bus = '0;
        if (code <= 4'd9) begin
            bus = 10'd1 << code;
        end
        return bus;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Frame-code debouncer: a code must repeat for DebFrames consecutive frames before it
// replaces the stable code. new_key_o strobes for one cycle when a real key is accepted.
module keypad_debounce
    import keypad_scan_pkg::*;
#(
    parameter int unsigned DebFrames = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  key_code_t frame_code_i,
    input  logic      frame_valid_i,
    output key_code_t stable_code_o,
    output logic      new_key_o
);

    localparam int unsigned CntW = $clog2(DebFrames + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebFrames);

    key_code_t       cand_q, cand_d;
    key_code_t       stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            new_key_q, new_key_d;

    // Candidate tracking and acceptance, evaluated only on frame-end cycles.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        new_key_d = 1'b0;
        if (frame_valid_i) begin
            if (frame_code_i == cand_q) begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = frame_code_i;
                cnt_d  = CntW'(1);
            end
            // Acceptance uses the updated run length so a full run lands on this edge.
            if (cnt_d == CntMax && cand_d != stable_q) begin
                stable_d  = cand_d;
                new_key_d = (cand_d <= KeyHash);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q    <= KeyNone;
            cnt_q     <= '0;
            stable_q  <= KeyNone;
            new_key_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            new_key_q <= new_key_d;
        end
    end

    assign stable_code_o = stable_q;
    assign new_key_o     = new_key_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: drives columns one-cold, folds the sampled rows of a frame into a
// single frame code, debounces it and decodes the accepted key onto the watch bus.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned ScanCycles = 2,
    parameter int unsigned DebFrames  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] key_row_i,
    output logic [2:0] key_col_o,
    output logic [9:0] keypad_o,
    output logic       key_star_o,
    output logic       key_hash_o,
    output logic       key_pulse_o
);

    localparam int unsigned CycW = (ScanCycles > 1) ? $clog2(ScanCycles) : 1;
    localparam logic [CycW-1:0] SlotLast = CycW'(ScanCycles - 1);

    scan_state_e     state_q, state_d;
    logic [CycW-1:0] slot_q, slot_d;
    logic            slot_end;
    logic [1:0]      col_idx;
    logic            sample;

    logic [1:0] acc_cnt_q, acc_cnt_d;
    key_code_t  acc_code_q, acc_code_d;
    logic [1:0] col_cnt;
    key_code_t  col_code;
    logic [1:0] base_cnt;
    key_code_t  base_code;
    logic [2:0] sum_cnt;
    key_code_t  sum_code;
    logic       frame_valid;
    key_code_t  frame_code;

    key_code_t  stable_code;
    logic       new_key;

    assign slot_end = (slot_q == SlotLast);

    // Scanner state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next column and slot position; StIdle hands over to column 0 on the first edge.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            StIdle:  state_d = StCol0;
            StCol0:  if (slot_end) state_d = StCol1;
            StCol1:  if (slot_end) state_d = StCol2;
            StCol2:  if (slot_end) state_d = StCol0;
            default: state_d = StIdle;
        endcase
        if (state_q == StIdle) begin
            slot_d = '0;
        end else begin
            slot_d = slot_end ? '0 : slot_q + 1'b1;
        end
    end

    // Column drive and sample strobe; rows are sampled only on the last cycle of a slot.
    always_comb begin
        key_col_o = 3'b111;
        col_idx   = 2'd0;
        sample    = 1'b0;
        unique case (state_q)
            StCol0: begin
                key_col_o = 3'b110;
                col_idx   = 2'd0;
                sample    = slot_end;
            end
            StCol1: begin
                key_col_o = 3'b101;
                col_idx   = 2'd1;
                sample    = slot_end;
            end
            StCol2: begin
                key_col_o = 3'b011;
                col_idx   = 2'd2;
                sample    = slot_end;
            end
            default: ;
        endcase
    end

    // Fold this column's contacts into the frame; count saturates at 2 meaning "many".
    always_comb begin
        col_cnt  = 2'd0;
        col_code = KeyNone;
        for (int r = 0; r < 4; r++) begin
            if (!key_row_i[r]) begin
                col_code = key_code(2'(r), col_idx);
                if (col_cnt != 2'd2) begin
                    col_cnt = col_cnt + 2'd1;
                end
            end
        end

        // Column 0 opens a new frame, so earlier contacts are discarded.
        base_cnt  = (col_idx == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code = (col_idx == 2'd0) ? KeyNone : acc_code_q;

        sum_cnt  = {1'b0, base_cnt} + {1'b0, col_cnt};
        if (sum_cnt > 3'd2) begin
            sum_cnt = 3'd2;
        end
        sum_code = (base_cnt != 2'd0) ? base_code : col_code;

        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            acc_cnt_d  = sum_cnt[1:0];
            acc_code_d = sum_code;
        end

        frame_valid = sample && (col_idx == 2'd2);
        unique case (sum_cnt)
            3'd0:    frame_code = KeyNone;
            3'd1:    frame_code = sum_code;
            default: frame_code = KeyMulti;
        endcase
    end

    // Contact accumulator registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= KeyNone;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    keypad_debounce #(
        .DebFrames (DebFrames)
    ) u_debounce (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .frame_code_i  (frame_code),
        .frame_valid_i (frame_valid),
        .stable_code_o (stable_code),
        .new_key_o     (new_key)
    );

    // Output decode straight off the registered stable code, so it changes on the
    // acceptance edge together with the pulse.
    always_comb begin
        keypad_o    = key_onehot(stable_code);
        key_star_o  = (stable_code == KeyStar);
        key_hash_o  = (stable_code == KeyHash);
        key_pulse_o = new_key;
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a frame-level model (contact lists and a history of the last
// DEB frame codes) is checked against the DUT every cycle, plus directed literal checks.
module tb_keypad_scan;

    localparam int S   = 2;
    localparam int DEB = 4;
    localparam int FR  = 3 * S;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [9:0]  keypad;
    logic        key_star;
    logic        key_hash;
    logic        key_pulse;
    logic [11:0] pressed = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int npulse     = 0;
    int nz_cycles  = 0;

    // Model state
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_stable = 15;
    bit m_pulse  = 1'b0;
    int m_contacts[$];
    int m_hist[$];

    keypad_scan #(
        .ScanCycles (S),
        .DebFrames  (DEB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_row_i   (key_row),
        .key_col_o   (key_col),
        .keypad_o    (keypad),
        .key_star_o  (key_star),
        .key_hash_o  (key_hash),
        .key_pulse_o (key_pulse)
    );

    initial forever #5 clk = ~clk;

    function automatic int krow(input int k);
        if (k >= 1 && k <= 9) return (k - 1) / 3;
        return 3;
    endfunction

    function automatic int kcol(input int k);
        if (k >= 1 && k <= 9) return (k - 1) % 3;
        if (k == 0) return 1;
        if (k == 10) return 0;
        return 2;
    endfunction

    // Membrane: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int k = 0; k < 12; k++) begin
            if (pressed[k] && !key_col[kcol(k)]) key_row[krow(k)] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame-level model
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_stable = 15;
            m_pulse  = 1'b0;
            m_contacts.delete();
            m_hist.delete();
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            m_pulse  = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_t % S == S - 1) begin
                int c;
                c = (m_t / S) % 3;
                for (int k = 0; k < 12; k++) begin
                    if (pressed[k] && kcol(k) == c) m_contacts.push_back(k);
                end
                if (c == 2) begin
                    int code;
                    bit same;
                    if (m_contacts.size() == 0) code = 15;
                    else if (m_contacts.size() == 1) code = m_contacts[0];
                    else code = 14;
                    m_contacts.delete();
                    m_hist.push_back(code);
                    if (m_hist.size() > DEB) void'(m_hist.pop_front());
                    same = (m_hist.size() == DEB);
                    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
                    if (same && m_hist[0] != m_stable) begin
                        m_stable = m_hist[0];
                        m_pulse  = (m_stable <= 11);
                    end
                end
            end
            m_t++;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        logic [2:0] e_col;
        logic [9:0] e_kp;
        @(negedge clk);
        e_col = m_active ? (3'b111 ^ (3'b001 << ((m_t / S) % 3))) : 3'b111;
        e_kp  = (m_stable < 10) ? (10'd1 << m_stable) : 10'd0;
        check("key_col", 32'(key_col), 32'(e_col));
        check("keypad", 32'(keypad), 32'(e_kp));
        check("key_star", 32'(key_star), 32'(m_stable == 10));
        check("key_hash", 32'(key_hash), 32'(m_stable == 11));
        check("key_pulse", 32'(key_pulse), 32'(m_pulse));
    end

    initial forever begin
        @(negedge clk);
        if (key_pulse) npulse++;
        if (keypad != 10'd0 || key_star || key_hash) nz_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Move to just after the start of a scan frame (column 0, first cycle).
    task automatic align_frame();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            if (m_active && (m_t % FR) == 0) begin
                found = 1'b1;
                break;
            end
        end
        #2;
        check("align_frame", 32'(found), 32'd1);
    endtask

    task automatic wait_kp(input logic [9:0] exp, input int budget, output int lat, output bit ok);
        int k0;
        k0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (keypad === exp) begin
                ok = 1'b1;
                break;
            end
        end
        lat = cyc - k0;
        #2;
    endtask

    initial begin
        logic [2:0] col_seq [6];
        int  lat;
        bit  ok;
        int  p0;
        int  nz0;

        col_seq = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011};

        // Reset state
        cycles(3);
        check("rst_key_col", 32'(key_col), 32'h7);
        check("rst_keypad", 32'(keypad), 32'h0);
        check("rst_pulse", 32'(key_pulse), 32'h0);
        rst_n = 1'b1;

        // T1 scan sequence
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t1_col_seq", 32'(key_col), 32'(col_seq[i % 6]));
        end
        #2;
        check("t1_idle_keypad", 32'(keypad), 32'h0);

        // T2 press '5' aligned with a frame, hold 10 frames, release
        align_frame();
        p0 = npulse;
        pressed[5] = 1'b1;
        wait_kp(10'b0000100000, 40, lat, ok);
        check("t2_accept", 32'(ok), 32'd1);
        check("t2_latency_24_30", 32'(lat >= 24 && lat <= 30), 32'd1);
        check("t2_keypad", 32'(keypad), 32'h020);
        check("t2_model_stable", 32'(m_stable), 32'd5);
        cycles(36);
        check("t2_one_pulse", 32'(npulse - p0), 32'd1);
        p0 = npulse;
        pressed = '0;
        wait_kp(10'b0, 40, lat, ok);
        check("t2_release", 32'(ok && lat <= 30), 32'd1);
        check("t2_release_nopulse", 32'(npulse - p0), 32'd0);

        // T3 bounce '7' every 2 frames for 20 frames, then hold
        align_frame();
        p0  = npulse;
        nz0 = nz_cycles;
        for (int r = 0; r < 5; r++) begin
            pressed[7] = 1'b1;
            cycles(2 * FR);
            pressed[7] = 1'b0;
            cycles(2 * FR);
        end
        check("t3_bounce_outputs", 32'(nz_cycles - nz0), 32'd0);
        check("t3_bounce_nopulse", 32'(npulse - p0), 32'd0);
        pressed[7] = 1'b1;
        wait_kp(10'b0010000000, 40, lat, ok);
        check("t3_accept", 32'(ok), 32'd1);
        cycles(4 * FR);
        check("t3_one_pulse", 32'(npulse - p0), 32'd1);
        pressed = '0;
        cycles(6 * FR);

        // T4 '1' + '9' together, then release '9'
        align_frame();
        p0 = npulse;
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        cycles(6 * FR);
        check("t4_multi_keypad", 32'(keypad), 32'h0);
        check("t4_multi_nopulse", 32'(npulse - p0), 32'd0);
        check("t4_model_multi", 32'(m_stable), 32'd14);
        pressed[9] = 1'b0;
        cycles(6 * FR);
        check("t4_keypad_1", 32'(keypad), 32'h002);
        check("t4_one_pulse", 32'(npulse - p0), 32'd1);
        pressed = '0;
        cycles(6 * FR);

        // T5 '*' then straight to '#'
        align_frame();
        p0 = npulse;
        pressed[10] = 1'b1;
        cycles(6 * FR);
        check("t5_star", 32'(key_star), 32'd1);
        check("t5_star_keypad", 32'(keypad), 32'h0);
        check("t5_star_pulse", 32'(npulse - p0), 32'd1);
        p0 = npulse;
        pressed = '0;
        pressed[11] = 1'b1;
        cycles(6 * FR);
        check("t5_hash_star", 32'(key_star), 32'd0);
        check("t5_hash", 32'(key_hash), 32'd1);
        check("t5_hash_pulse", 32'(npulse - p0), 32'd1);
        pressed = '0;
        cycles(6 * FR);

        // T6 hold '0', reset mid-frame, re-accept
        align_frame();
        pressed[0] = 1'b1;
        cycles(6 * FR);
        check("t6_keypad_0", 32'(keypad), 32'h001);
        align_frame();
        cycles(3);
        rst_n = 1'b0;
        cycles(1);
        check("t6_rst_col", 32'(key_col), 32'h7);
        check("t6_rst_keypad", 32'(keypad), 32'h0);
        check("t6_rst_pulse", 32'(key_pulse), 32'h0);
        cycles(2);
        p0 = npulse;
        rst_n = 1'b1;
        wait_kp(10'b0000000001, 40, lat, ok);
        check("t6_reaccept", 32'(ok), 32'd1);
        cycles(2 * FR);
        check("t6_fresh_pulse", 32'(npulse - p0), 32'd1);
        pressed = '0;
        cycles(6 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
